// File: rtl/in_service_if.sv
// Bus between the interrupt controller core (resolver/IRR/data buffer side)
// and the in-service controller.
interface in_service_if;
    logic [7:0] priority_in;
    logic [2:0] priority_id;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] is_status;
    logic [7:0] last_serviced;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output priority_in, priority_id, inta_n, vector_base, aeoi,
               eoi_valid, eoi_cmd, eoi_level,
        input  int_out, is_status, last_serviced, irr_clear, data_out, data_oe
    );

    modport slave (
        input  priority_in, priority_id, inta_n, vector_base, aeoi,
               eoi_valid, eoi_cmd, eoi_level,
        output int_out, is_status, last_serviced, irr_clear, data_out, data_oe
    );
endinterface

// File: rtl/in_service_controller.sv
// In-service controller: two-pulse INTA handshake, ISR upkeep, OCW2 EOI and
// rotation commands. int_out is the only combinational output.
module in_service_controller (
    input  logic         clk,
    input  logic         rst,
    in_service_if.slave  bus
);
    localparam int unsigned NUM_IRQ = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK1 = 2'd1;
    localparam logic [1:0] ACK2 = 2'd2;

    localparam logic [2:0] CMD_NS_EOI  = 3'b001;
    localparam logic [2:0] CMD_SP_EOI  = 3'b011;
    localparam logic [2:0] CMD_ROT_NS  = 3'b101;
    localparam logic [2:0] CMD_ROT_SP  = 3'b111;
    localparam logic [2:0] CMD_SET_PRI = 3'b110;

    logic [1:0] state, state_n;
    logic       inta_q;
    logic [2:0] sel_id, sel_id_n;
    logic       spurious, spurious_n;
    logic [7:0] is_q, is_n;
    logic [7:0] ls_q, ls_n;
    logic [7:0] irr_q, irr_n;
    logic [7:0] dout_q, dout_n;
    logic       doe_q, doe_n;

    logic       fall, rise;
    logic [7:0] is_set, is_clr;
    logic [2:0] ls_id;
    logic [2:0] scan_id;
    logic [2:0] hp_id;
    logic       hp_found;

    assign fall = inta_q & ~bus.inta_n;
    assign rise = ~inta_q & bus.inta_n;

    // Index of the current lowest-priority level.
    always_comb begin
        ls_id = 3'd0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (ls_q[i]) ls_id = 3'(i);
        end
    end

    // Highest-priority in-service level, scanning cyclically from ls_id+1.
    always_comb begin
        hp_found = 1'b0;
        hp_id    = 3'd0;
        scan_id  = 3'd0;
        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            scan_id = ls_id + 3'(k) + 3'd1;
            if (!hp_found && is_q[scan_id]) begin
                hp_found = 1'b1;
                hp_id    = scan_id;
            end
        end
    end

    // Next-state, handshake and OCW2 command decode.
    always_comb begin
        state_n    = state;
        sel_id_n   = sel_id;
        spurious_n = spurious;
        is_set     = 8'd0;
        is_clr     = 8'd0;
        ls_n       = ls_q;
        irr_n      = 8'd0;
        dout_n     = dout_q;
        doe_n      = doe_q;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = ACK1;
                    if (|bus.priority_in) begin
                        sel_id_n             = bus.priority_id;
                        spurious_n           = 1'b0;
                        is_set[bus.priority_id] = 1'b1;
                        irr_n                = bus.priority_in;
                    end else begin
                        sel_id_n   = 3'd7;
                        spurious_n = 1'b1;
                    end
                end
            end
            ACK1: begin
                doe_n = 1'b0;
                if (fall) begin
                    state_n = ACK2;
                    dout_n  = {bus.vector_base, sel_id};
                    doe_n   = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_n = IDLE;
                    doe_n   = 1'b0;
                    if (bus.aeoi && !spurious) is_clr[sel_id] = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                doe_n   = 1'b0;
            end
        endcase

        if (bus.eoi_valid) begin
            case (bus.eoi_cmd)
                CMD_NS_EOI: begin
                    if (hp_found) is_clr[hp_id] = 1'b1;
                end
                CMD_ROT_NS: begin
                    if (hp_found) begin
                        is_clr[hp_id] = 1'b1;
                        ls_n          = 8'd0;
                        ls_n[hp_id]   = 1'b1;
                    end
                end
                CMD_SP_EOI: begin
                    is_clr[bus.eoi_level] = 1'b1;
                end
                CMD_ROT_SP: begin
                    is_clr[bus.eoi_level] = 1'b1;
                    ls_n                  = 8'd0;
                    ls_n[bus.eoi_level]   = 1'b1;
                end
                CMD_SET_PRI: begin
                    ls_n                = 8'd0;
                    ls_n[bus.eoi_level] = 1'b1;
                end
                default: ;
            endcase
        end

        // A set on the same edge as a clear of the same bit wins.
        is_n = (is_q & ~is_clr) | is_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inta_q   <= 1'b1;
            sel_id   <= 3'd0;
            spurious <= 1'b0;
            is_q     <= 8'd0;
            ls_q     <= 8'h80;
            irr_q    <= 8'd0;
            dout_q   <= 8'd0;
            doe_q    <= 1'b0;
        end else begin
            state    <= state_n;
            inta_q   <= bus.inta_n;
            sel_id   <= sel_id_n;
            spurious <= spurious_n;
            is_q     <= is_n;
            ls_q     <= ls_n;
            irr_q    <= irr_n;
            dout_q   <= dout_n;
            doe_q    <= doe_n;
        end
    end

    assign bus.int_out       = (state == IDLE) && (|bus.priority_in);
    assign bus.is_status     = is_q;
    assign bus.last_serviced = ls_q;
    assign bus.irr_clear     = irr_q;
    assign bus.data_out      = dout_q;
    assign bus.data_oe       = doe_q;
endmodule

// File: doc/in_service_controller.md
# in_service_controller

Consumes the one-hot winner from the priority resolver, runs the two-pulse 8086-style INTA handshake with the CPU, maintains the In-Service Register, and executes OCW2 end-of-interrupt and rotation commands. Sits between the priority resolver, the IRR, and the data-bus buffer. It drives back the `is_status` and `last_serviced` vectors that the resolver uses for nesting masks and rotation.

## Interface
- No parameters.
- `clk` in 1: single system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `priority_in` in 8: one-hot resolver winner (all-zero = no request).
- `priority_id` in 3: binary index of `priority_in`.
- `inta_n` in 1: CPU acknowledge, active low. Synchronous to `clk`, each low/high phase ≥1 cycle.
- `vector_base` in 5: ICW2 T7..T3.
- `aeoi` in 1: ICW4 auto-EOI enable.
- `eoi_valid` in 1: one-cycle OCW2 strobe.
- `eoi_cmd` in 3: OCW2 {R,SL,EOI}.
  - 001 non-specific EOI
  - 011 specific EOI
  - 101 rotate on non-specific EOI
  - 111 rotate on specific EOI
  - 110 set priority
  - others: no-op
- `eoi_level` in 3: OCW2 L2..L0.
- `int_out` out 1: interrupt request to CPU.
- `is_status` out 8: ISR contents.
- `last_serviced` out 8: one-hot lowest-priority level.
- `irr_clear` out 8: one-cycle one-hot pulse to clear the acknowledged IRR bit.
- `data_out` out 8: interrupt vector.
- `data_oe` out 1: vector drive enable.

## Operation
- Edge detection: `inta_q` registers `inta_n`.
  - fall = `inta_q & ~inta_n`
  - rise = `~inta_q & inta_n`
- **IDLE:** `int_out` = |`priority_in`.
  - On fall with a request: latch `sel_id`=`priority_id` and set `is_status[sel_id]`.
  - In the same edge, pulse `irr_clear` = `priority_in`, drop `int_out`, and go to **ACK1**.
  - On fall with no request (spurious): `sel_id`=7, no ISR set, no `irr_clear`, go to **ACK1**.
- **ACK1:** `data_oe`=0, `int_out`=0. On the next fall, go to **ACK2**.
- **ACK2:** `data_out`={`vector_base`,`sel_id`}, `data_oe`=1.
  - On rise: `data_oe`=0 and return to **IDLE**.
  - If `aeoi`=1 and the request was not spurious, clear `is_status[sel_id]` on that same edge. `last_serviced` is unchanged.
- Priority order: highest priority is (`ls_id`+1) mod 8, where `ls_id` is the index of `last_serviced`. Priority then descends cyclically.
- **Non-specific EOI** (001/101): clear the highest-priority set ISR bit. If 101, `last_serviced` ← that bit. If ISR is empty, no change.
- **Specific EOI** (011/111): clear `is_status[eoi_level]`. If 111, `last_serviced` ← 1<<`eoi_level`, even if the bit was already clear.
- **Set priority** (110): `last_serviced` ← 1<<`eoi_level`; ISR untouched.
- EOI commands are accepted in any FSM state.
- Same-edge set and clear of the same ISR bit: the set wins.

## Timing
- Reset values:
  - `is_status`=0, `last_serviced`=8'h80 (IR0 highest), FSM=**IDLE**, `inta_q`=1
  - `data_out`=0, `data_oe`=0, `irr_clear`=0
  - `int_out` follows `priority_in` combinationally in **IDLE** (0 when no request).
- `rst` during **ACK1**/**ACK2** aborts the handshake: next cycle is **IDLE** with reset values. The CPU's remaining INTA pulses are treated as a new sequence.
- Latencies:
  - ISR set: visible 1 cycle after the edge that sees `inta_n` low following high.
  - `irr_clear`: high exactly one cycle.
  - `data_out`/`data_oe`: valid from the cycle after the second fall is detected until the cycle after the rise is detected. All outputs are registered except `int_out`.
  - EOI effects: visible on `is_status`/`last_serviced` one cycle after `eoi_valid`.
- `priority_in` changes while in **ACK1**/**ACK2** are ignored. `sel_id` is frozen at the first fall.
- `int_out` re-asserts in **IDLE** the cycle after return if a request is pending.

## Test plan
- Reset → `is_status`=0, `last_serviced`=8'h80, `data_oe`=0, `irr_clear`=0.
- `priority_in`=8'h08, `vector_base`=5'h11, two INTA pulses → `irr_clear`=8'h08 for 1 cycle, `is_status`=8'h08, `data_out`=8'h8B during pulse 2, `int_out` low after the first fall.
- `aeoi`=1, `priority_in`=8'h01 handshake → `is_status` returns to 0 after the second rise, `last_serviced` stays 8'h80.
- ISR=8'h24, `last_serviced`=8'h04, `eoi_cmd`=101 → clears bit 5, ISR=8'h04, `last_serviced`=8'h20.
- INTA with `priority_in`=0 → `data_out`={`vector_base`,3'b111}, ISR unchanged, no `irr_clear`.
- `rst` asserted in **ACK1** → **IDLE**, ISR=0. A fresh pair of pulses with `priority_in`=8'h02 completes normally with vector id 1.
